// File: rtl/fwrisc_decode.sv
// fwrisc decode stage: latches a fetched RV32I(+M) instruction, reads rs1/rs2
// from the synchronous register file, and presents the decoded operation to
// exec on the decode_valid/exec_ready handshake.
module fwrisc_decode #(
  parameter bit ENABLE_MUL_DIV = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_valid,
  output logic        decode_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [5:0]  ra_raddr,
  output logic [5:0]  rb_raddr,
  input  logic [31:0] ra_rdata,
  input  logic [31:0] rb_rdata,
  output logic        decode_valid,
  input  logic        exec_ready,
  output logic [1:0]  op_type,
  output logic [5:0]  op,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [31:0] op_c,
  output logic [5:0]  rd_raddr,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, RDREG, CAPTURE, VALID} state_t;

  localparam logic [1:0] OPT_ALU  = 2'd0;
  localparam logic [1:0] OPT_LDST = 2'd1;
  localparam logic [1:0] OPT_JUMP = 2'd2;
  localparam logic [1:0] OPT_MDS  = 2'd3;

  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SUB  = 6'd1;
  localparam logic [5:0] ALU_AND  = 6'd2;
  localparam logic [5:0] ALU_OR   = 6'd3;
  localparam logic [5:0] ALU_XOR  = 6'd4;
  localparam logic [5:0] ALU_SLT  = 6'd5;
  localparam logic [5:0] ALU_SLTU = 6'd6;
  localparam logic [5:0] MDS_SLL  = 6'd0;
  localparam logic [5:0] MDS_SRL  = 6'd1;
  localparam logic [5:0] MDS_SRA  = 6'd2;
  localparam logic [5:0] MDS_MUL  = 6'd3;
  localparam logic [5:0] JMP_JAL  = 6'd8;
  localparam logic [5:0] JMP_JALR = 6'd9;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  state_t      state, state_nxt;
  logic [31:0] instr_q, pc_q;
  logic        accept;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [31:0] rs1_val, rs2_val, jalr_sum;

  logic        d_ill;
  logic [1:0]  d_type;
  logic [5:0]  d_op;
  logic [31:0] d_a, d_b, d_c;
  logic [5:0]  d_rd;

  // Map a register-register / immediate funct3 onto the ALU op code.
  function automatic logic [5:0] alu_op(input logic [2:0] f3);
    case (f3)
      3'd2:    alu_op = ALU_SLT;
      3'd3:    alu_op = ALU_SLTU;
      3'd4:    alu_op = ALU_XOR;
      3'd6:    alu_op = ALU_OR;
      3'd7:    alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  endfunction

  assign accept = fetch_valid && decode_ready;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt    = state;
    decode_ready = 1'b0;
    decode_valid = 1'b0;
    case (state)
      IDLE: begin
        decode_ready = 1'b1;
        if (fetch_valid) state_nxt = RDREG;
      end
      RDREG:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = VALID;
      VALID: begin
        decode_valid = 1'b1;
        if (exec_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the accepted instruction and present its source addresses to the regfile.
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_q  <= '0;
      pc_q     <= '0;
      ra_raddr <= '0;
      rb_raddr <= '0;
    end else if (accept) begin
      instr_q  <= instr;
      pc_q     <= pc;
      ra_raddr <= {1'b0, instr[19:15]};
      rb_raddr <= {1'b0, instr[24:20]};
    end
  end

  assign opcode   = instr_q[6:0];
  assign funct3   = instr_q[14:12];
  assign funct7   = instr_q[31:25];
  assign imm_i    = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s    = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b    = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_j    = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
  assign imm_u    = {instr_q[31:12], 12'b0};
  assign rs1_val  = (instr_q[19:15] == 5'd0) ? '0 : ra_rdata;
  assign rs2_val  = (instr_q[24:20] == 5'd0) ? '0 : rb_rdata;
  assign jalr_sum = rs1_val + imm_i;

  // Decode the latched instruction against the freshly read register data.
  always_comb begin
    d_ill  = 1'b0;
    d_type = OPT_ALU;
    d_op   = '0;
    d_a    = '0;
    d_b    = '0;
    d_c    = '0;
    d_rd   = {1'b0, instr_q[11:7]};
    case (opcode)
      OPC_LUI: begin
        d_b = imm_u;
      end
      OPC_AUIPC: begin
        d_a = pc_q;
        d_b = imm_u;
      end
      OPC_JAL: begin
        d_type = OPT_JUMP;
        d_op   = JMP_JAL;
        d_a    = pc_q;
        d_b    = 32'd4;
        d_c    = pc_q + imm_j;
      end
      OPC_JALR: begin
        d_ill  = (funct3 != 3'd0);
        d_type = OPT_JUMP;
        d_op   = JMP_JALR;
        d_a    = pc_q;
        d_b    = 32'd4;
        d_c    = {jalr_sum[31:1], 1'b0};
      end
      OPC_BRANCH: begin
        d_ill  = (funct3 == 3'd2) || (funct3 == 3'd3);
        d_type = OPT_JUMP;
        d_op   = {3'b000, funct3};
        d_a    = rs1_val;
        d_b    = rs2_val;
        d_c    = pc_q + imm_b;
        d_rd   = '0;
      end
      OPC_LOAD: begin
        d_ill  = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        d_type = OPT_LDST;
        d_op   = {3'b000, funct3};
        d_a    = rs1_val;
        d_b    = imm_i;
      end
      OPC_STORE: begin
        d_ill  = (funct3 > 3'd2);
        d_type = OPT_LDST;
        d_op   = {1'b1, 2'b00, funct3};
        d_a    = rs1_val;
        d_b    = imm_s;
        d_c    = rs2_val;
        d_rd   = '0;
      end
      OPC_OPIMM: begin
        d_a = rs1_val;
        d_b = imm_i;
        if (funct3 == 3'd1) begin
          d_ill  = (funct7 != 7'b0000000);
          d_type = OPT_MDS;
          d_op   = MDS_SLL;
          d_b    = {27'b0, instr_q[24:20]};
        end else if (funct3 == 3'd5) begin
          d_ill  = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          d_type = OPT_MDS;
          d_op   = instr_q[30] ? MDS_SRA : MDS_SRL;
          d_b    = {27'b0, instr_q[24:20]};
        end else begin
          d_op = alu_op(funct3);
        end
      end
      OPC_OP: begin
        d_a = rs1_val;
        d_b = rs2_val;
        if (funct7 == 7'b0000001) begin
          d_ill  = !ENABLE_MUL_DIV;
          d_type = OPT_MDS;
          d_op   = MDS_MUL + {3'b000, funct3};
        end else if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          // instr[30] picks SUB/SRA; it is only legal on funct3 0 and 5.
          d_ill = instr_q[30] && (funct3 != 3'd0) && (funct3 != 3'd5);
          if (funct3 == 3'd1) begin
            d_type = OPT_MDS;
            d_op   = MDS_SLL;
          end else if (funct3 == 3'd5) begin
            d_type = OPT_MDS;
            d_op   = instr_q[30] ? MDS_SRA : MDS_SRL;
          end else if (funct3 == 3'd0) begin
            d_op = instr_q[30] ? ALU_SUB : ALU_ADD;
          end else begin
            d_op = alu_op(funct3);
          end
        end else begin
          d_ill = 1'b1;
        end
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_type = OPT_ALU;
      d_op   = '0;
      d_a    = '0;
      d_b    = '0;
      d_c    = '0;
      d_rd   = '0;
    end
  end

  // Register the decoded operation in CAPTURE; it then holds through VALID.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_type  <= '0;
      op       <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_c     <= '0;
      rd_raddr <= '0;
      illegal  <= 1'b0;
    end else if (state == CAPTURE) begin
      op_type  <= d_type;
      op       <= d_op;
      op_a     <= d_a;
      op_b     <= d_b;
      op_c     <= d_c;
      rd_raddr <= d_rd;
      illegal  <= d_ill;
    end
  end

endmodule

// File: tb/tb_fwrisc_decode.sv
// Bench for fwrisc_decode: two instances (M-extension on and off) share the
// fetch/exec stimulus, each with its own synchronous register-file model.
module tb_fwrisc_decode;

  typedef struct packed {
    logic        ill;
    logic [1:0]  t;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [5:0]  rd;
  } dec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_valid = 1'b0;
  logic        exec_ready = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;

  logic        decode_ready1, decode_valid1, illegal1;
  logic [5:0]  ra_raddr1, rb_raddr1, op1, rd_raddr1;
  logic [31:0] ra_rdata1, rb_rdata1, op_a1, op_b1, op_c1;
  logic [1:0]  op_type1;

  logic        decode_ready0, decode_valid0, illegal0;
  logic [5:0]  ra_raddr0, rb_raddr0, op0, rd_raddr0;
  logic [31:0] ra_rdata0, rb_rdata0, op_a0, op_b0, op_c0;
  logic [1:0]  op_type0;

  logic [31:0] regs [32];
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  always #5 clock = ~clock;

  fwrisc_decode #(.ENABLE_MUL_DIV(1'b1)) u_dut1 (
    .clock(clock), .reset(reset), .fetch_valid(fetch_valid), .decode_ready(decode_ready1),
    .instr(instr), .pc(pc), .ra_raddr(ra_raddr1), .rb_raddr(rb_raddr1),
    .ra_rdata(ra_rdata1), .rb_rdata(rb_rdata1), .decode_valid(decode_valid1),
    .exec_ready(exec_ready), .op_type(op_type1), .op(op1), .op_a(op_a1), .op_b(op_b1),
    .op_c(op_c1), .rd_raddr(rd_raddr1), .illegal(illegal1)
  );

  fwrisc_decode #(.ENABLE_MUL_DIV(1'b0)) u_dut0 (
    .clock(clock), .reset(reset), .fetch_valid(fetch_valid), .decode_ready(decode_ready0),
    .instr(instr), .pc(pc), .ra_raddr(ra_raddr0), .rb_raddr(rb_raddr0),
    .ra_rdata(ra_rdata0), .rb_rdata(rb_rdata0), .decode_valid(decode_valid0),
    .exec_ready(exec_ready), .op_type(op_type0), .op(op0), .op_a(op_a0), .op_b(op_b0),
    .op_c(op_c0), .rd_raddr(rd_raddr0), .illegal(illegal0)
  );

  // Synchronous register files: data appears the cycle after the address.
  always @(posedge clock) begin
    ra_rdata1 <= regs[ra_raddr1[4:0]];
    rb_rdata1 <= regs[rb_raddr1[4:0]];
    ra_rdata0 <= regs[ra_raddr0[4:0]];
    rb_rdata0 <= regs[rb_raddr0[4:0]];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic dec_t outs1();
    return {illegal1, op_type1, op1, op_a1, op_b1, op_c1, rd_raddr1};
  endfunction

  function automatic dec_t outs0();
    return {illegal0, op_type0, op0, op_a0, op_b0, op_c0, rd_raddr0};
  endfunction

  // Reference decoder built from the ISA field layout with plain arithmetic.
  function automatic dec_t model(input logic [31:0] w, input logic [31:0] p,
                                 input logic [31:0] r1, input logic [31:0] r2, input bit md);
    dec_t d;
    int unsigned opc, f3, f7, sh;
    bit ok;
    logic signed [31:0] sw, hi_i, hi_s, sgn;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    int unsigned alu_tbl [8];
    alu_tbl = '{0, 0, 5, 6, 4, 0, 3, 2};
    opc = w & 32'h7F;
    f3  = (w >> 12) & 7;
    f7  = w >> 25;
    sh  = (w >> 20) & 31;
    sw    = w;
    hi_i  = sw >>> 20;
    hi_s  = sw >>> 25;
    sgn   = sw >>> 31;
    imm_i = hi_i;
    imm_s = (hi_s << 5) | ((w >> 7) & 31);
    imm_b = (sgn << 12) | (((w >> 7) & 1) << 11) | (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1);
    imm_j = (sgn << 20) | (((w >> 12) & 255) << 12) | (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1);
    imm_u = w & 32'hFFFFF000;
    d = '0;
    ok = 1;
    d.rd = 6'((w >> 7) & 31);
    case (opc)
      7'h37: begin d.b = imm_u; end
      7'h17: begin d.a = p; d.b = imm_u; end
      7'h6F: begin d.t = 2; d.op = 8; d.a = p; d.b = 4; d.c = p + imm_j; end
      7'h67: begin ok = (f3 == 0); d.t = 2; d.op = 9; d.a = p; d.b = 4; d.c = (r1 + imm_i) & 32'hFFFFFFFE; end
      7'h63: begin ok = (f3 != 2 && f3 != 3); d.t = 2; d.op = 6'(f3); d.a = r1; d.b = r2; d.c = p + imm_b; d.rd = 0; end
      7'h03: begin ok = (f3 <= 2 || f3 == 4 || f3 == 5); d.t = 1; d.op = 6'(f3); d.a = r1; d.b = imm_i; end
      7'h23: begin ok = (f3 <= 2); d.t = 1; d.op = 6'(32 + f3); d.a = r1; d.b = imm_s; d.c = r2; d.rd = 0; end
      7'h13: begin
        d.a = r1; d.b = imm_i;
        if (f3 == 1) begin ok = (f7 == 0); d.t = 3; d.op = 0; d.b = sh; end
        else if (f3 == 5) begin ok = (f7 == 0 || f7 == 32); d.t = 3; d.op = (f7 == 32) ? 2 : 1; d.b = sh; end
        else d.op = 6'(alu_tbl[f3]);
      end
      7'h33: begin
        d.a = r1; d.b = r2;
        if (f7 == 1) begin ok = md; d.t = 3; d.op = 6'(3 + f3); end
        else if (f7 == 0) begin
          if (f3 == 1) begin d.t = 3; d.op = 0; end
          else if (f3 == 5) begin d.t = 3; d.op = 1; end
          else d.op = 6'(alu_tbl[f3]);
        end else if (f7 == 32) begin
          if (f3 == 0) d.op = 1;
          else if (f3 == 5) begin d.t = 3; d.op = 2; end
          else ok = 0;
        end else ok = 0;
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      d = '0;
      d.ill = 1;
    end
    return d;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'h37;
      1: w[6:0] = 7'h17;
      2: w[6:0] = 7'h6F;
      3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h03;
      6: w[6:0] = 7'h23;
      7: w[6:0] = 7'h13;
      8: w[6:0] = 7'h33;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction

  // One full transaction: accept, latency, hold in VALID for 'hold' cycles, transfer.
  task automatic run_instr(input logic [31:0] w, input logic [31:0] a_pc, input logic [31:0] v1,
                           input logic [31:0] v2, input int unsigned hold,
                           output dec_t got1, output dec_t got0);
    int unsigned rs1, rs2, guard;
    dec_t e1, e0;
    rs1 = (w >> 15) & 31;
    rs2 = (w >> 20) & 31;
    regs[rs1] = v1;
    regs[rs2] = v2;
    regs[0] = 32'hBAD0_BAD0;
    e1 = model(w, a_pc, (rs1 == 0) ? 32'd0 : regs[rs1], (rs2 == 0) ? 32'd0 : regs[rs2], 1'b1);
    e0 = model(w, a_pc, (rs1 == 0) ? 32'd0 : regs[rs1], (rs2 == 0) ? 32'd0 : regs[rs2], 1'b0);
    guard = 0;
    while (decode_ready1 !== 1'b1 && guard < 10) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (decode_ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_wait: decode_ready=%b required 1", decode_ready1);
    end
    instr = w; pc = a_pc; fetch_valid = 1'b1; exec_ready = 1'($urandom_range(0, 1));
    tick();
    fetch_valid = 1'($urandom_range(0, 1)); instr = $urandom; pc = $urandom;
    exec_ready = 1'($urandom_range(0, 1));
    n_cmp++;
    if ({ra_raddr1, rb_raddr1, ra_raddr0, rb_raddr0} !== {6'(rs1), 6'(rs2), 6'(rs1), 6'(rs2)}) begin
      n_fail++;
      $display("FAIL raddr: got %h/%h %h/%h required %h/%h", ra_raddr1, rb_raddr1, ra_raddr0, rb_raddr0, rs1, rs2);
    end
    n_cmp++;
    if ({decode_ready1, decode_valid1} !== 2'b00) begin
      n_fail++;
      $display("FAIL busy_after_accept: ready=%b valid=%b required 0 0", decode_ready1, decode_valid1);
    end
    tick();
    exec_ready = 1'($urandom_range(0, 1));
    n_cmp++;
    if (decode_valid1 !== 1'b0 || decode_valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL early_valid: valid=%b/%b required 0", decode_valid1, decode_valid0);
    end
    tick();
    n_cmp++;
    if (decode_valid1 !== 1'b1 || decode_valid0 !== 1'b1) begin
      n_fail++;
      $display("FAIL latency: valid=%b/%b required 1", decode_valid1, decode_valid0);
    end
    got1 = outs1();
    got0 = outs0();
    n_cmp++;
    if (got1 !== e1) begin
      n_fail++;
      $display("FAIL decode_md1 instr=%h pc=%h: got %h required %h", w, a_pc, got1, e1);
    end
    n_cmp++;
    if (got0 !== e0) begin
      n_fail++;
      $display("FAIL decode_md0 instr=%h pc=%h: got %h required %h", w, a_pc, got0, e0);
    end
    exec_ready = 1'b0;
    for (int unsigned k = 0; k < hold; k++) begin
      tick();
      n_cmp++;
      if (decode_valid1 !== 1'b1 || outs1() !== e1 || outs0() !== e0) begin
        n_fail++;
        $display("FAIL hold_stable cycle %0d: valid=%b got %h required %h", k, decode_valid1, outs1(), e1);
      end
    end
    exec_ready = 1'b1;
    tick();
    fetch_valid = 1'b0;
    exec_ready = 1'b0;
    n_cmp++;
    if ({decode_valid1, decode_ready1, decode_valid0, decode_ready0} !== 4'b0101) begin
      n_fail++;
      $display("FAIL transfer: valid/ready=%b%b %b%b required 01 01", decode_valid1, decode_ready1,
               decode_valid0, decode_ready0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({decode_ready1, decode_valid1, illegal1} !== 3'b100 || {op_type1, op1, op_a1, op_b1, op_c1, rd_raddr1, ra_raddr1, rb_raddr1} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b valid=%b ill=%b outs=%h required 1 0 0 zeros", decode_ready1,
               decode_valid1, illegal1, {op_type1, op1, op_a1, op_b1, op_c1, rd_raddr1, ra_raddr1, rb_raddr1});
    end
    reset = 1'b0;
  endtask

  task automatic test_addi();
    dec_t g1, g0;
    run_instr(32'h00500093, 32'h0, $urandom, $urandom, 0, g1, g0);
    n_cmp++;
    if ({g1.t, g1.op, g1.a, g1.b, g1.rd, g1.ill} !== {2'd0, 6'd0, 32'd0, 32'd5, 6'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL addi: got t=%0d op=%0d a=%h b=%h rd=%0d ill=%b required 0 0 0 5 1 0", g1.t, g1.op, g1.a, g1.b, g1.rd, g1.ill);
    end
  endtask

  task automatic test_lui_auipc();
    dec_t g1, g0;
    run_instr(32'h12345137, 32'h0FC, $urandom, $urandom, 0, g1, g0);
    n_cmp++;
    if ({g1.a, g1.b, g1.rd} !== {32'd0, 32'h12345000, 6'd2}) begin
      n_fail++;
      $display("FAIL lui: got a=%h b=%h rd=%0d required 0 12345000 2", g1.a, g1.b, g1.rd);
    end
    run_instr(32'h00001197, 32'h100, $urandom, $urandom, 0, g1, g0);
    n_cmp++;
    if ({g1.a, g1.b, g1.rd} !== {32'h100, 32'h1000, 6'd3}) begin
      n_fail++;
      $display("FAIL auipc: got a=%h b=%h rd=%0d required 100 1000 3", g1.a, g1.b, g1.rd);
    end
  endtask

  task automatic test_branch_hold();
    dec_t g1, g0;
    run_instr(32'h00208463, 32'h200, 32'd7, 32'd7, 5, g1, g0);
    n_cmp++;
    if ({g1.t, g1.a, g1.b, g1.c, g1.rd} !== {2'd2, 32'd7, 32'd7, 32'h208, 6'd0}) begin
      n_fail++;
      $display("FAIL beq: got t=%0d a=%h b=%h c=%h rd=%0d required 2 7 7 208 0", g1.t, g1.a, g1.b, g1.c, g1.rd);
    end
    tick();
    n_cmp++;
    if (decode_valid1 !== 1'b0 || decode_ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL single_transfer: valid=%b ready=%b required 0 1", decode_valid1, decode_ready1);
    end
  endtask

  task automatic test_store();
    dec_t g1, g0;
    run_instr(32'h00532223, 32'h40, 32'h1000, 32'hDEADBEEF, 1, g1, g0);
    n_cmp++;
    if ({g1.t, g1.op, g1.a, g1.b, g1.c, g1.rd} !== {2'd1, 6'b100010, 32'h1000, 32'd4, 32'hDEADBEEF, 6'd0}) begin
      n_fail++;
      $display("FAIL sw: got t=%0d op=%b a=%h b=%h c=%h rd=%0d required 1 100010 1000 4 deadbeef 0",
               g1.t, g1.op, g1.a, g1.b, g1.c, g1.rd);
    end
  endtask

  task automatic test_illegal();
    dec_t g1, g0;
    run_instr(32'h00000000, 32'h80, $urandom, $urandom, 0, g1, g0);
    n_cmp++;
    if ({g1.ill, g1.t, g1.rd, g0.ill} !== {1'b1, 2'd0, 6'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_word: got ill=%b t=%0d rd=%0d ill0=%b required 1 0 0 1", g1.ill, g1.t, g1.rd, g0.ill);
    end
    run_instr(32'h023100B3, 32'h84, $urandom, $urandom, 0, g1, g0);
    n_cmp++;
    if ({g0.ill, g0.t, g0.rd, g0.a} !== {1'b1, 2'd0, 6'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL mul_disabled: got ill=%b t=%0d rd=%0d a=%h required 1 0 0 0", g0.ill, g0.t, g0.rd, g0.a);
    end
    n_cmp++;
    if ({g1.ill, g1.t, g1.op, g1.rd} !== {1'b0, 2'd3, 6'd3, 6'd1}) begin
      n_fail++;
      $display("FAIL mul_enabled: got ill=%b t=%0d op=%0d rd=%0d required 0 3 3 1", g1.ill, g1.t, g1.op, g1.rd);
    end
  endtask

  task automatic test_reset_midflight();
    dec_t g1, g0;
    instr = 32'h00500093; fetch_valid = 1'b1;
    tick();
    fetch_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({decode_valid1, decode_ready1, decode_valid0, decode_ready0} !== 4'b0101) begin
      n_fail++;
      $display("FAIL reset_in_rdreg: valid/ready=%b%b %b%b required 01 01", decode_valid1, decode_ready1, decode_valid0, decode_ready0);
    end
    run_instr(32'h00A30293, 32'h300, $urandom, $urandom, 0, g1, g0);
    instr = 32'h12345137; fetch_valid = 1'b1;
    tick();
    fetch_valid = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (decode_valid1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reach_valid: valid=%b required 1", decode_valid1);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({decode_valid1, decode_ready1, illegal1, op_b1, rd_raddr1} !== {1'b0, 1'b1, 1'b0, 32'd0, 6'd0}) begin
      n_fail++;
      $display("FAIL reset_in_valid: valid=%b ready=%b b=%h rd=%0d required 0 1 0 0", decode_valid1, decode_ready1, op_b1, rd_raddr1);
    end
    tick();
    tick();
    n_cmp++;
    if (decode_valid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL no_ghost_valid: valid=%b required 0", decode_valid1);
    end
    run_instr(32'h0062C1B3, 32'h304, $urandom, $urandom, 0, g1, g0);
  endtask

  task automatic test_random();
    dec_t g1, g0;
    for (int i = 0; i < 200; i++)
      run_instr(rand_instr(), $urandom, $urandom, $urandom, $urandom_range(0, 2), g1, g0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    test_reset();
    test_addi();
    test_lui_auipc();
    test_branch_hold();
    test_store();
    test_illegal();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
